game_cmd_scheduler: RTL and testbench

Front-end controller for the 8x8 block-placement game engine. It turns raw, already-debounced button levels into one-cycle command pulses (move, rotate, place, select) that the game engine consumes. Simultaneous requests are arbitrated by fixed priority and spaced by a minimum gap. A game-session FSM (idle, clear, play, over) generates the engine's restart pulse and blocks commands outside of play.

---
 rtl/game_cmd_scheduler.sv | 152 +++++++++++++++
 tb/tb_game_cmd_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_cmd_scheduler.sv
// Button-level to command-pulse front end: edge detect, pending set, fixed-priority issue with gap, session FSM.
// Optional auto-repeat on direction buttons is built when AUTO_REPEAT_EN is defined.
module game_cmd_scheduler #(
  parameter int GAP          = 2,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_rotate,
  input  logic       btn_place,
  input  logic       btn_sel1,
  input  logic       btn_sel2,
  input  logic       btn_sel3,
  input  logic       btn_start,
  input  logic       game_over,
  output logic       move_left,
  output logic       move_right,
  output logic       move_up,
  output logic       move_down,
  output logic       rotate_block,
  output logic       place_block,
  output logic       sel1,
  output logic       sel2,
  output logic       sel3,
  output logic       game_rst,
  output logic [1:0] state,
  output logic       busy
);

  localparam int GW = (GAP < 1) ? 1 : $clog2(GAP + 1);
  localparam logic [GW-1:0] GAP_LD = GW'(GAP);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CLEAR = 2'd1, S_PLAY = 2'd2, S_OVER = 2'd3} state_t;

  state_t        state_reg, state_next;
  logic [8:0]    pending_reg, pending_next;
  logic [GW-1:0] gap_reg, gap_next;
  logic [9:0]    prev_reg;
  logic [8:0]    cmd_reg, grant;
  logic          game_rst_reg, game_rst_next;
  logic [9:0]    btn_vec, edges;
  logic [8:0]    rep_req, req;

  // Bit index equals priority rank: bit 0 (place) wins, bit 8 (down) loses.
  assign btn_vec = {btn_start, btn_down, btn_up, btn_right, btn_left,
                    btn_sel3, btn_sel2, btn_sel1, btn_rotate, btn_place};
  assign edges   = btn_vec & ~prev_reg;
  assign req     = edges[8:0] | rep_req;

`ifdef AUTO_REPEAT_EN
  assign rep_req[4:0] = '0;
  for (genvar gi = 0; gi < 4; gi++) begin : g_repeat
    logic [15:0] hold_cnt_reg;
    logic        rep_phase_reg;
    logic [15:0] thr;
    logic        hit;
    logic        btn;

    assign btn = btn_vec[5+gi];
    // First request after REPEAT_DELAY held cycles, then every REPEAT_RATE.
    assign thr = rep_phase_reg ? 16'(REPEAT_RATE) : 16'(REPEAT_DELAY);
    assign hit = btn && ((hold_cnt_reg + 16'd1) == thr);
    assign rep_req[5+gi] = hit && (state_reg == S_PLAY);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hold_cnt_reg  <= '0;
        rep_phase_reg <= 1'b0;
      end else if (!btn || state_reg == S_CLEAR) begin
        hold_cnt_reg  <= '0;
        rep_phase_reg <= 1'b0;
      end else if (hit) begin
        hold_cnt_reg  <= '0;
        rep_phase_reg <= 1'b1;
      end else begin
        hold_cnt_reg  <= hold_cnt_reg + 16'd1;
      end
    end
  end
`else
  assign rep_req = '0;
`endif

  always_comb begin
    state_next    = state_reg;
    pending_next  = pending_reg;
    gap_next      = (gap_reg != '0) ? gap_reg - 1'b1 : '0;
    grant         = '0;
    case (state_reg)
      S_IDLE, S_OVER: begin
        pending_next = '0;
        if (edges[9]) state_next = S_CLEAR;
      end
      S_CLEAR: begin
        pending_next = '0;
        gap_next     = '0;
        state_next   = S_PLAY;
      end
      default: begin
        if (game_over) begin
          state_next   = S_OVER;
          pending_next = '0;
        end else begin
          if (gap_reg == '0 && pending_reg != '0) begin
            // Isolate the lowest set bit, i.e. the highest-priority request.
            grant    = pending_reg & (~pending_reg + 9'd1);
            gap_next = GAP_LD;
          end
          pending_next = (pending_reg & ~grant) | req;
        end
      end
    endcase
    game_rst_next = (state_next == S_CLEAR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      pending_reg  <= '0;
      gap_reg      <= '0;
      prev_reg     <= '0;
      cmd_reg      <= '0;
      game_rst_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pending_reg  <= pending_next;
      gap_reg      <= gap_next;
      prev_reg     <= btn_vec;
      cmd_reg      <= grant;
      game_rst_reg <= game_rst_next;
    end
  end

  assign place_block  = cmd_reg[0];
  assign rotate_block = cmd_reg[1];
  assign sel1         = cmd_reg[2];
  assign sel2         = cmd_reg[3];
  assign sel3         = cmd_reg[4];
  assign move_left    = cmd_reg[5];
  assign move_right   = cmd_reg[6];
  assign move_up      = cmd_reg[7];
  assign move_down    = cmd_reg[8];
  assign game_rst     = game_rst_reg;
  assign state        = state_reg;
  assign busy         = (pending_reg != '0) || (gap_reg != '0);

endmodule

// File: tb/tb_game_cmd_scheduler.sv
// Directed self-checking bench for game_cmd_scheduler (GAP=2, REPEAT_DELAY=8, REPEAT_RATE=4).
`timescale 1ns/1ps
module tb_game_cmd_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_left = 0, btn_right = 0, btn_up = 0, btn_down = 0;
  logic btn_rotate = 0, btn_place = 0, btn_sel1 = 0, btn_sel2 = 0, btn_sel3 = 0;
  logic btn_start = 0, game_over = 0;
  logic move_left, move_right, move_up, move_down, rotate_block, place_block;
  logic sel1, sel2, sel3, game_rst, busy;
  logic [1:0] state;
  logic [8:0] cmd_out;

  int checks = 0;
  int errors = 0;

  localparam logic [8:0] C_PLACE = 9'h001, C_ROTATE = 9'h002, C_SEL2 = 9'h008,
                         C_LEFT = 9'h020, C_RIGHT = 9'h040, C_UP = 9'h080, C_DOWN = 9'h100;

  always #5 clk = ~clk;

  game_cmd_scheduler #(.GAP(2), .REPEAT_DELAY(8), .REPEAT_RATE(4)) dut (
    .clk(clk), .reset(reset),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
    .btn_rotate(btn_rotate), .btn_place(btn_place),
    .btn_sel1(btn_sel1), .btn_sel2(btn_sel2), .btn_sel3(btn_sel3),
    .btn_start(btn_start), .game_over(game_over),
    .move_left(move_left), .move_right(move_right), .move_up(move_up), .move_down(move_down),
    .rotate_block(rotate_block), .place_block(place_block),
    .sel1(sel1), .sel2(sel2), .sel3(sel3),
    .game_rst(game_rst), .state(state), .busy(busy)
  );

  assign cmd_out = {move_down, move_up, move_right, move_left, sel3, sel2, sel1, rotate_block, place_block};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick();
    tick();
    checks++;
    if ({cmd_out, game_rst, busy, state} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got cmd=%h rst=%b busy=%b state=%0d, expected all 0", cmd_out, game_rst, busy, state);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL reset_idle: got state=%0d expected 0", state);
    end
    $display("test_reset done");
  endtask

  task automatic test_start;
    btn_start = 1'b1;
    tick();
    btn_start = 1'b0;
    checks++;
    if (state !== 2'd1 || game_rst !== 1'b1) begin
      errors++;
      $display("FAIL start_clear: got state=%0d rst=%b expected 1/1", state, game_rst);
    end
    tick();
    checks++;
    if (state !== 2'd2 || game_rst !== 1'b0) begin
      errors++;
      $display("FAIL start_play: got state=%0d rst=%b expected 2/0", state, game_rst);
    end
    tick();
    checks++;
    if (state !== 2'd2 || game_rst !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_settle: got state=%0d rst=%b busy=%b expected 2/0/0", state, game_rst, busy);
    end
    $display("test_start done");
  endtask

  task automatic test_single;
    logic [8:0] exp_cmd [4] = '{9'h000, C_LEFT, 9'h000, 9'h000};
    logic       exp_busy[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    btn_left = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      btn_left = 1'b0;
      checks++;
      if (cmd_out !== exp_cmd[i] || busy !== exp_busy[i]) begin
        errors++;
        $display("FAIL single_left[%0d]: got cmd=%h busy=%b expected cmd=%h busy=%b",
                 i, cmd_out, busy, exp_cmd[i], exp_busy[i]);
      end
    end
    $display("test_single done");
  endtask

  task automatic test_priority;
    logic [8:0] expv;
    btn_place = 1'b1; btn_rotate = 1'b1; btn_right = 1'b1;
    tick();
    btn_place = 1'b0; btn_rotate = 1'b0; btn_right = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      expv = (i == 1) ? C_PLACE : (i == 4) ? C_ROTATE : (i == 7) ? C_RIGHT : 9'h000;
      checks++;
      if (cmd_out !== expv) begin
        errors++;
        $display("FAIL priority[%0d]: got cmd=%h expected %h", i, cmd_out, expv);
      end
    end
    $display("test_priority done");
  endtask

  task automatic test_repeat;
    int pulses = 0;
    int multi = 0;
    btn_down = 1'b1;
    for (int i = 0; i < 42; i++) begin
      tick();
      if (i == 29) btn_down = 1'b0;
      if (move_down === 1'b1) pulses++;
      if ($countones(cmd_out) > 1) multi++;
    end
    checks++;
    if (multi != 0) begin
      errors++;
      $display("FAIL repeat_onehot: got %0d multi-pulse cycles expected 0", multi);
    end
`ifdef AUTO_REPEAT_EN
    checks++;
    if (pulses < 5) begin
      errors++;
      $display("FAIL repeat_count: got %0d pulses expected >=5", pulses);
    end
`else
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL repeat_count: got %0d pulses expected 1", pulses);
    end
`endif
    $display("test_repeat done: %0d down pulses", pulses);
  endtask

  task automatic test_game_over;
    int stray = 0;
    btn_place = 1'b1; btn_sel2 = 1'b1;
    tick();
    btn_place = 1'b0; btn_sel2 = 1'b0;
    tick();
    checks++;
    if (cmd_out !== C_PLACE) begin
      errors++;
      $display("FAIL over_place: got cmd=%h expected %h", cmd_out, C_PLACE);
    end
    tick();
    tick();
    game_over = 1'b1;
    tick();
    checks++;
    if (state !== 2'd3 || cmd_out !== 9'h000) begin
      errors++;
      $display("FAIL over_enter: got state=%0d cmd=%h expected 3/000", state, cmd_out);
    end
    btn_left = 1'b1; btn_sel1 = 1'b1;
    tick();
    btn_left = 1'b0; btn_sel1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cmd_out !== 9'h000) stray++;
    end
    checks++;
    if (stray != 0 || busy !== 1'b0 || state !== 2'd3) begin
      errors++;
      $display("FAIL over_blocked: got stray=%0d busy=%b state=%0d expected 0/0/3", stray, busy, state);
    end
    game_over = 1'b0;
    btn_start = 1'b1;
    tick();
    btn_start = 1'b0;
    checks++;
    if (state !== 2'd1 || game_rst !== 1'b1) begin
      errors++;
      $display("FAIL over_restart: got state=%0d rst=%b expected 1/1", state, game_rst);
    end
    tick();
    checks++;
    if (state !== 2'd2 || game_rst !== 1'b0) begin
      errors++;
      $display("FAIL over_play: got state=%0d rst=%b expected 2/0", state, game_rst);
    end
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cmd_out !== 9'h000) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL over_no_stale: got %0d stray pulses expected 0", stray);
    end
    $display("test_game_over done");
  endtask

  task automatic test_reset_mid;
    int stray = 0;
    btn_up = 1'b1; btn_down = 1'b1;
    tick();
    btn_up = 1'b0; btn_down = 1'b0;
    tick();
    checks++;
    if (cmd_out !== C_UP || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_issue: got cmd=%h busy=%b expected %h/1", cmd_out, busy, C_UP);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({cmd_out, game_rst, busy, state} !== 13'd0) begin
      errors++;
      $display("FAIL mid_async_reset: got cmd=%h rst=%b busy=%b state=%0d expected all 0", cmd_out, game_rst, busy, state);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cmd_out !== 9'h000 || state !== 2'd0) stray++;
    end
    checks++;
    if (stray != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_after_release: got %0d bad cycles busy=%b expected 0/0", stray, busy);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_start();
    test_single();
    test_priority();
    test_repeat();
    test_game_over();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
